pipeline_mem_arbiter: RTL and testbench

Sequences the single-ported RAM between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the pipelined processor. A registered grant FSM holds one requester on the RAM until the transfer completes or aborts. Data has priority, and a starvation limit protects fetch. Sits between the pipeline's memory interfaces and the RAM model.

---
 rtl/cpu_types_pkg.sv | 7 +
 rtl/pipeline_mem_arbiter_if.sv | 29 ++
 rtl/pipeline_mem_arbiter.sv | 43 ++++
 tb/tb_pipeline_mem_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the pipelined processor and its memory arbiter.
package cpu_types_pkg;
  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// pipeline_mem_arbiter_if: fetch, memory-stage and RAM signals seen by the arbiter.
interface pipeline_mem_arbiter_if;
  import cpu_types_pkg::*;
  logic iREN;
  word_t iaddr;
  logic iwait;
  word_t iload;
  logic dREN;
  logic dWEN;
  word_t daddr;
  word_t dstore;
  logic dwait;
  word_t dload;
  logic ramREN;
  logic ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  ramstate_t ramstate;
  logic merr;
  modport slave (
    input iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: grants the single-ported RAM to fetch or memory stage, data first with a fetch starvation limit.
module pipeline_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic CLK,
  input logic nRST,
  pipeline_mem_arbiter_if.slave bus
);
  arb_state_t state, nxt;
  logic [3:0] starve_cnt;
  logic dreq, fin, force_i, icomp, dcomp;
  always_comb begin
    dreq = bus.dREN || bus.dWEN;
    fin = bus.ramstate == ACCESS || bus.ramstate == ERROR;
    force_i = bus.iREN && starve_cnt == 4'(STARVE_LIMIT);
    icomp = state == IGRANT && bus.iREN && fin;
    dcomp = state == DGRANT && dreq && fin;
    // a dropped request falls back to IDLE as an abort, never as a completion
    nxt = state == IDLE ? (dreq && !force_i ? DGRANT : bus.iREN ? IGRANT : IDLE)
        : state == IGRANT ? (bus.iREN && !fin ? IGRANT : IDLE)
        : (dreq && !fin ? DGRANT : IDLE);
    bus.ramREN = state == IGRANT ? bus.iREN : state == DGRANT ? bus.dREN && !bus.dWEN : 1'b0;
    bus.ramWEN = state == DGRANT && bus.dWEN;
    bus.ramaddr = state == IGRANT ? bus.iaddr : state == DGRANT ? bus.daddr : '0;
    bus.ramstore = state == DGRANT ? bus.dstore : '0;
    bus.iload = state == IGRANT ? bus.ramload : '0;
    bus.dload = state == DGRANT ? bus.ramload : '0;
    bus.iwait = !icomp;
    bus.dwait = !dcomp;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) starve_cnt <= '0;
    else if (icomp && bus.ramstate == ACCESS) starve_cnt <= '0;
    else if (dcomp && bus.iREN && starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) bus.merr <= 1'b0;
    else if ((icomp || dcomp) && bus.ramstate == ERROR) bus.merr <= 1'b1;
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb_pipeline_mem_arbiter: directed stimulus with a per-cycle ownership model and literal spot checks.
module tb_pipeline_mem_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  pipeline_mem_arbiter_if bus();
  pipeline_mem_arbiter #(.STARVE_LIMIT(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  int total = 0;
  int passed = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
  endtask
  // owner: 0 = nobody, 1 = fetch, 2 = memory stage
  int owner = 0, starve = 0, nxt_owner = 0, nxt_starve = 0;
  bit merr_m = 0, nxt_merr = 0;
  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      owner = 0; starve = 0; merr_m = 0;
    end else begin
      owner = nxt_owner; starve = nxt_starve; merr_m = nxt_merr;
    end
  always @(negedge CLK) begin
    bit dreq, fin, idone, ddone;
    dreq = bus.dREN || bus.dWEN;
    fin = bus.ramstate inside {ACCESS, ERROR};
    idone = owner == 1 && bus.iREN && fin;
    ddone = owner == 2 && dreq && fin;
    chk("iwait", 32'(bus.iwait), 32'(!idone));
    chk("dwait", 32'(bus.dwait), 32'(!ddone));
    chk("ramREN", 32'(bus.ramREN), owner == 1 ? 32'(bus.iREN) : owner == 2 ? 32'(bus.dREN && !bus.dWEN) : 32'd0);
    chk("ramWEN", 32'(bus.ramWEN), 32'(owner == 2 && bus.dWEN));
    chk("ramaddr", bus.ramaddr, owner == 1 ? bus.iaddr : owner == 2 ? bus.daddr : 32'd0);
    chk("ramstore", bus.ramstore, owner == 2 ? bus.dstore : 32'd0);
    chk("iload", bus.iload, owner == 1 ? bus.ramload : 32'd0);
    chk("dload", bus.dload, owner == 2 ? bus.ramload : 32'd0);
    chk("merr", 32'(bus.merr), 32'(merr_m));
    chk("starve", 32'(dut.starve_cnt), 32'(starve));
    nxt_merr = merr_m || ((idone || ddone) && bus.ramstate == ERROR);
    nxt_starve = (idone && bus.ramstate == ACCESS) ? 0 : (ddone && bus.iREN) ? (starve < 4 ? starve + 1 : 4) : starve;
    if (owner == 0) nxt_owner = (dreq && !(bus.iREN && starve == 4)) ? 2 : bus.iREN ? 1 : 0;
    else if (owner == 1) nxt_owner = (bus.iREN && !fin) ? 1 : 0;
    else nxt_owner = (dreq && !fin) ? 2 : 0;
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  initial begin
    int dl, il;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
    step(2);
    chk("rst_iwait", 32'(bus.iwait), 32'd1);
    chk("rst_dwait", 32'(bus.dwait), 32'd1);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_merr", 32'(bus.merr), 32'd0);
    nRST = 1;
    step;
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY; bus.ramload = 32'h1234_5678;
    step;
    chk("i_ramREN", 32'(bus.ramREN), 32'd1);
    chk("i_ramaddr", bus.ramaddr, 32'h40);
    chk("i_busy_wait", 32'(bus.iwait), 32'd1);
    step;
    chk("i_busy2_wait", 32'(bus.iwait), 32'd1);
    bus.ramstate = ACCESS;
    #1;
    chk("i_done_wait", 32'(bus.iwait), 32'd0);
    chk("i_iload", bus.iload, 32'h1234_5678);
    step;
    bus.iREN = 0; bus.ramstate = FREE;
    #1;
    chk("i_idle_ramREN", 32'(bus.ramREN), 32'd0);
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
    bus.ramstate = ACCESS;
    step;
    chk("dw_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("dw_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    chk("dw_ramaddr", bus.ramaddr, 32'h100);
    chk("dw_dwait", 32'(bus.dwait), 32'd0);
    chk("dw_iwait", 32'(bus.iwait), 32'd1);
    step;
    bus.dWEN = 0;
    #1;
    chk("dw_idle_iwait", 32'(bus.iwait), 32'd1);
    chk("dw_starve1", 32'(dut.starve_cnt), 32'd1);
    step;
    chk("ig_after_d_iwait", 32'(bus.iwait), 32'd0);
    chk("ig_after_d_addr", bus.ramaddr, 32'h80);
    step;
    bus.iREN = 0;
    #1;
    chk("ig_starve_clr", 32'(dut.starve_cnt), 32'd0);
    bus.iREN = 1; bus.dREN = 1; bus.ramstate = ACCESS;
    dl = 0; il = 0;
    repeat (8) begin
      step;
      if (!bus.dwait) dl++;
      if (!bus.iwait) il++;
    end
    chk("starve_dcount", 32'(dl), 32'd4);
    chk("starve_icount", 32'(il), 32'd0);
    chk("starve_sat", 32'(dut.starve_cnt), 32'd4);
    step;
    chk("starve_forced_i", 32'(bus.iwait), 32'd0);
    chk("starve_forced_d", 32'(bus.dwait), 32'd1);
    step;
    bus.iREN = 0; bus.dREN = 0;
    #1;
    chk("starve_clr", 32'(dut.starve_cnt), 32'd0);
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hA5A5_A5A5;
    step;
    chk("rw_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("rw_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rw_dwait", 32'(bus.dwait), 32'd0);
    step;
    bus.dREN = 0; bus.dWEN = 0;
    bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = ERROR;
    step;
    chk("err_iwait", 32'(bus.iwait), 32'd0);
    step;
    bus.iREN = 0; bus.ramstate = ACCESS;
    #1;
    chk("err_merr", 32'(bus.merr), 32'd1);
    chk("err_starve", 32'(dut.starve_cnt), 32'd0);
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramload = 32'h0BAD_F00D;
    step;
    chk("post_err_dwait", 32'(bus.dwait), 32'd0);
    chk("post_err_dload", bus.dload, 32'h0BAD_F00D);
    step;
    bus.dREN = 0;
    #1;
    chk("merr_sticky", 32'(bus.merr), 32'd1);
    bus.iREN = 1; bus.dREN = 1;
    step;
    chk("ab_pre_dwait", 32'(bus.dwait), 32'd0);
    step;
    bus.iREN = 0; bus.ramstate = BUSY;
    step;
    chk("ab_busy_dwait", 32'(bus.dwait), 32'd1);
    bus.dREN = 0;
    #1;
    chk("ab_ramREN", 32'(bus.ramREN), 32'd0);
    chk("ab_dwait", 32'(bus.dwait), 32'd1);
    step;
    chk("ab_starve", 32'(dut.starve_cnt), 32'd1);
    chk("ab_idle_dwait", 32'(bus.dwait), 32'd1);
    bus.dWEN = 1; bus.daddr = 32'h400; bus.dstore = 32'h1111_2222;
    step;
    chk("rst_mid_ramWEN_pre", 32'(bus.ramWEN), 32'd1);
    #2 nRST = 0;
    #1;
    chk("rst_mid_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_mid_dwait", 32'(bus.dwait), 32'd1);
    chk("rst_mid_merr", 32'(bus.merr), 32'd0);
    chk("rst_mid_ramaddr", bus.ramaddr, 32'd0);
    step;
    nRST = 1; bus.dWEN = 0; bus.ramstate = FREE;
    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
